// File: rtl/updown_auto_player_if.sv
// Guess/feedback bundle between the auto player (master) and the game core or bench (slave).
// Pure wiring: no storage and no flow control.
`timescale 1ns/1ps
interface updown_auto_player_if;
    logic       start;
    logic [6:0] seg_display;
    logic       guess_trigger;
    logic [6:0] user_input;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] guess_count;

    modport master (
        input  start, seg_display,
        output guess_trigger, user_input, busy, done, found, guess_count
    );

    modport slave (
        output start, seg_display,
        input  guess_trigger, user_input, busy, done, found, guess_count
    );
endinterface

// File: rtl/updown_auto_player.sv
// Binary-search player for the up/down game: one guess per RESP_WAIT+2 cycles, done one cycle after the deciding sample.
// No backpressure: start is honoured only in IDLE; unrecognised feedback is retried until the timeout runs out.
`timescale 1ns/1ps
module updown_auto_player #(
    parameter int         RESP_WAIT = 2,
    parameter int         TIMEOUT   = 16,
    parameter logic [6:0] SEG_UP    = 7'b0111110,
    parameter logic [6:0] SEG_DOWN  = 7'b1011110,
    parameter logic [6:0] SEG_HIT   = 7'b0111111
) (
    input  logic                        clk,
    input  logic                        reset,
    updown_auto_player_if.master        bus
);

    localparam logic [3:0] WAIT_LD = 4'(RESP_WAIT);
    localparam logic [7:0] TMO_LD  = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_FINISH
    } state_t;

    state_t     state_q;
    logic [6:0] lo_q, hi_q;
    logic [6:0] user_input_q;
    logic       trig_q, busy_q, done_q, found_q;
    logic [3:0] count_q;
    logic [3:0] wait_q;
    logic [7:0] tmo_q;

    logic [6:0] lo_d, hi_d, mid_d;
    logic [7:0] sum_d;
    logic [3:0] count_d;
    logic       is_up, is_down, is_hit;

    assign is_up   = (bus.seg_display == SEG_UP);
    assign is_down = (bus.seg_display == SEG_DOWN);
    assign is_hit  = (bus.seg_display == SEG_HIT);

    // Bounds the next guess is taken from; the guess register is loaded on entry to DRIVE
    // so the trigger and its value are visible in the DRIVE cycle itself.
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (state_q == S_IDLE) begin
            lo_d = 7'd0;
            hi_d = 7'd127;
        end else if (is_up) begin
            lo_d = user_input_q + 7'd1;
        end else if (is_down) begin
            hi_d = user_input_q - 7'd1;
        end
        sum_d   = {1'b0, lo_d} + {1'b0, hi_d};
        mid_d   = 7'(sum_d >> 1);
        count_d = (count_q == 4'd15) ? 4'd15 : count_q + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            lo_q         <= 7'd0;
            hi_q         <= 7'd127;
            user_input_q <= 7'd0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            count_q      <= 4'd0;
            wait_q       <= 4'd0;
            tmo_q        <= 8'd0;
        end else begin
            trig_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        lo_q         <= lo_d;
                        hi_q         <= hi_d;
                        found_q      <= 1'b0;
                        count_q      <= 4'd1;
                        user_input_q <= mid_d;
                        trig_q       <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    wait_q  <= WAIT_LD;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q <= 4'd1) begin
                        tmo_q   <= TMO_LD;
                        state_q <= S_SAMPLE;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (is_hit) begin
                        found_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else if (is_up) begin
                        if (user_input_q == 7'd127 || user_input_q == hi_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            lo_q         <= lo_d;
                            user_input_q <= mid_d;
                            trig_q       <= 1'b1;
                            count_q      <= count_d;
                            state_q      <= S_DRIVE;
                        end
                    end else if (is_down) begin
                        if (user_input_q == 7'd0 || user_input_q == lo_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            hi_q         <= hi_d;
                            user_input_q <= mid_d;
                            trig_q       <= 1'b1;
                            count_q      <= count_d;
                            state_q      <= S_DRIVE;
                        end
                    end else if (tmo_q <= 8'd1) begin
                        // Timeout budget spent: the last unrecognised sample ends the search.
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        tmo_q <= tmo_q - 8'd1;
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.guess_trigger = trig_q;
    assign bus.user_input    = user_input_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.found         = found_q;
    assign bus.guess_count   = count_q;

endmodule

// File: tb/tb_updown_auto_player.sv
// Directed bench for updown_auto_player: a target-driven game model answers each guess and
// every search is checked for guess sequence, spacing, done timing and final outputs.
`timescale 1ns/1ps
module tb_updown_auto_player;
    localparam int         RESP_WAIT = 2;
    localparam int         TIMEOUT   = 16;
    localparam logic [6:0] SEG_UP    = 7'b0111110;
    localparam logic [6:0] SEG_DOWN  = 7'b1011110;
    localparam logic [6:0] SEG_HIT   = 7'b0111111;
    localparam int         PERIOD    = RESP_WAIT + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    updown_auto_player_if bus();

    updown_auto_player #(
        .RESP_WAIT (RESP_WAIT),
        .TIMEOUT   (TIMEOUT),
        .SEG_UP    (SEG_UP),
        .SEG_DOWN  (SEG_DOWN),
        .SEG_HIT   (SEG_HIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 0: honest game with a hidden target, 1: always "d", 2: blank display
    int mode = 0;
    int target = 0;
    logic [6:0] seg;

    always_comb begin
        seg = 7'h00;
        if (mode == 0) begin
            if (int'(bus.user_input) == target)     seg = SEG_HIT;
            else if (target > int'(bus.user_input)) seg = SEG_UP;
            else                                    seg = SEG_DOWN;
        end else if (mode == 1) begin
            seg = SEG_DOWN;
        end
    end
    assign bus.seg_display = seg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int gq[$];
    int gcyc[$];
    int exp_guess[$];
    int done_seen = 0;
    int t0 = 0;

    always @(negedge clk) begin
        if (bus.guess_trigger === 1'b1) begin
            gq.push_back(int'(bus.user_input));
            gcyc.push_back(cyc);
        end
        if (bus.done === 1'b1) done_seen++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_trig"},  32'(bus.guess_trigger), 0);
        chk({tag, "_ui"},    32'(bus.user_input),    0);
        chk({tag, "_busy"},  32'(bus.busy),          0);
        chk({tag, "_done"},  32'(bus.done),          0);
        chk({tag, "_found"}, 32'(bus.found),         0);
        chk({tag, "_count"}, 32'(bus.guess_count),   0);
    endtask

    // Starts a search, optionally re-pulses start at poke_rel, and checks the outcome.
    task automatic run(input string tag, input int exp_found, input int exp_cnt,
                       input int exp_ui, input int exp_done_rel, input int poke_rel);
        int  rel;
        int  done_rel;
        bit  got;
        int  n;
        gq.delete();
        gcyc.delete();
        @(negedge clk);
        bus.start = 1'b1;
        t0 = cyc;
        got = 1'b0;
        done_rel = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            bus.start = (rel == poke_rel);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                done_rel = rel;
            end
        end
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 1);
        chk({tag, "_done_cycle"}, 32'(done_rel), 32'(exp_done_rel));
        chk({tag, "_found"}, 32'(bus.found), 32'(exp_found));
        chk({tag, "_count"}, 32'(bus.guess_count), 32'(exp_cnt));
        chk({tag, "_ui"}, 32'(bus.user_input), 32'(exp_ui));
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 1);
        chk({tag, "_n_guesses"}, 32'(gq.size()), 32'(exp_guess.size()));
        n = (gq.size() < exp_guess.size()) ? gq.size() : exp_guess.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_guess%0d", tag, i), 32'(gq[i]), 32'(exp_guess[i]));
        if (gcyc.size() > 0)
            chk({tag, "_first_trig"}, 32'(gcyc[0] - t0), 1);
        for (int i = 1; i < gcyc.size(); i++)
            chk($sformatf("%s_spacing%0d", tag, i), 32'(gcyc[i] - gcyc[i-1]), PERIOD);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 0);
        chk({tag, "_busy_after"}, 32'(bus.busy), 0);
        chk({tag, "_found_held"}, 32'(bus.found), 32'(exp_found));
    endtask

    initial begin
        int seen0;
        bus.start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        mode = 0; target = 100;
        exp_guess = {63, 95, 111, 103, 99, 101, 100};
        run("t100", 1, 7, 100, 7*PERIOD+1, -1);

        target = 127;
        exp_guess = {63, 95, 111, 119, 123, 125, 126, 127};
        run("t127", 1, 8, 127, 8*PERIOD+1, -1);

        target = 63;
        exp_guess = {63};
        run("t63", 1, 1, 63, 5, -1);

        mode = 1;
        exp_guess = {63, 31, 15, 7, 3, 1, 0};
        run("down", 0, 7, 0, 7*PERIOD+1, -1);

        mode = 2;
        exp_guess = {63};
        run("stuck", 0, 1, 63, PERIOD+TIMEOUT, -1);

        // Reset during WAIT of a stuck search: outputs clear at once, no done follows.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        seen0 = done_seen;
        reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("midreset_no_done", 32'(done_seen - seen0), 0);
        chk("midreset_idle_busy", 32'(bus.busy), 0);

        mode = 0; target = 63;
        exp_guess = {63};
        run("restart", 1, 1, 63, 5, -1);

        target = 100;
        exp_guess = {63, 95, 111, 103, 99, 101, 100};
        run("poke", 1, 7, 100, 7*PERIOD+1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/updown_auto_player.md
# updown_auto_player

Automatic player for the up/down number-guessing game. It drives the game's guess inputs (`user_input`, `guess_trigger`) and decodes the game's 7-segment feedback (`seg_display`). A binary search finds the hidden 7-bit number in at most 8 guesses. It sits beside the game core in self-play builds and in regression benches, in place of the human or stimulus driver.

## Interface
- `RESP_WAIT`, 2: cycles after a trigger pulse before `seg_display` is sampled (1..15).
- `TIMEOUT`, 16: extra cycles to keep sampling while `seg_display` shows no recognised pattern; on expiry the search fails (1..255).
- `SEG_UP`, 7'b0111110: feedback pattern "U": target is higher than the guess.
- `SEG_DOWN`, 7'b1011110: feedback pattern "d": target is lower than the guess.
- `SEG_HIT`, 7'b0111111: feedback pattern "0": guess correct.

Ports:
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begins a search; sampled only in IDLE.
- `seg_display` in 7: game feedback, gfedcba order, active-high segments.
- `guess_trigger` out 1: one-cycle guess pulse to the game.
- `user_input` out 7: current guess; held between pulses.
- `busy` out 1: high from the cycle after `start` is accepted until `done` is asserted.
- `done` out 1: one-cycle pulse when the search ends.
- `found` out 1: valid from `done` until the next accepted `start`. 1 = hit, 0 = fail.
- `guess_count` out 4: number of guesses issued in the current or last search.

## Operation
- States: IDLE, DRIVE, WAIT, SAMPLE, FINISH.
- Search bounds `lo` and `hi` are 7-bit registers.
- Guess: `mid = (lo + hi) >> 1`, computed with an 8-bit sum so there is no overflow.
- IDLE, `start`=1: set `lo`=0, `hi`=127, `guess_count`=0, `found`=0. Go to DRIVE.
- DRIVE (1 cycle):
  - `user_input` <= `mid`; `guess_trigger`=1.
  - `guess_count` +1 (saturates at 15).
  - Load the wait counter with `RESP_WAIT`. Go to WAIT.
- WAIT: count down `RESP_WAIT` cycles. Go to SAMPLE. Load the timeout counter with `TIMEOUT`.
- SAMPLE, by `seg_display`:
  - == `SEG_HIT`: `found` <= 1. Go to FINISH.
  - == `SEG_UP`:
    - If `user_input`==127 or `user_input`==`hi`, feedback is inconsistent: go to FINISH with `found`=0.
    - Else `lo` <= `user_input`+1. Go to DRIVE.
  - == `SEG_DOWN`:
    - If `user_input`==0 or `user_input`==`lo`, feedback is inconsistent: go to FINISH with `found`=0.
    - Else `hi` <= `user_input`-1. Go to DRIVE.
  - Any other pattern: stay in SAMPLE and decrement the timeout counter. At 0, go to FINISH with `found`=0.
- FINISH (1 cycle): `done`=1. Go to IDLE.
- `start` while not IDLE is ignored. `start` held high re-arms a new search on the cycle after FINISH.
- Every state other than IDLE asserts `busy`; FINISH is included.

## Timing
- Reset values: state IDLE, `guess_trigger`=0, `user_input`=0, `busy`=0, `done`=0, `found`=0, `guess_count`=0, `lo`=0, `hi`=127.
- Cycle 0: `start` sampled in IDLE. Cycle 1: DRIVE. `guess_trigger` and the new `user_input` are valid in the same cycle.
- Sample point: `seg_display` is first sampled `RESP_WAIT`+1 cycles after the trigger cycle.
- Guess period with recognised feedback: `RESP_WAIT`+2 cycles (4 at default).
- `done` follows the deciding SAMPLE cycle by one cycle. `found` and `guess_count` are stable in that cycle.
- Worst-case successful search: 8 guesses, i.e. 8·(`RESP_WAIT`+2)+2 cycles from `start`.
- `reset` asserted mid-search: every output returns to its reset value immediately. No `done` pulse is produced.
- All outputs are registered.

## Test plan
- Target 100, default parameters:
  - Guesses 63, 95, 111, 103, 99, 101, 100.
  - Feedback U, U, d, d, U, d, hit.
  - Required: `done` with `found`=1, `guess_count`=7, `user_input`=100.
- Target 127:
  - Guesses 63, 95, 111, 119, 123, 125, 126, 127.
  - Required: `found`=1, `guess_count`=8. Check the 8-bit `mid` sum (126+127).
- Target 63: required a single guess of 63, `found`=1, `guess_count`=1. Trigger spacing is exactly 4 cycles; `done` arrives 5 cycles after `start`.
- Feedback always `SEG_DOWN`:
  - Guesses 63, 31, 15, 7, 3, 1, 0.
  - The 7th "d" (at guess 0) gives `found`=0, `guess_count`=7.
- Stuck feedback and reset:
  - `seg_display`=7'h00 after the first guess. Required: `done` with `found`=0 after `TIMEOUT` sample cycles; `guess_count`=1.
  - Repeat the search and assert `reset` during WAIT. Required: immediate reset values; no `done`; a new `start` restarts from 63.
- `start` pulsed during WAIT: required to be ignored. The guess sequence and the total count are unchanged.
